// File: rtl/controller_sequencer_pkg.sv
// Shared SAP-1 definitions: opcodes, control-word bit positions, T-state
// one-hot codes and the control-word decode used by the sequencer.
package controller_sequencer_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_CP     = 11;
    localparam int CW_EP     = 10;
    localparam int CW_LM_N   = 9;
    localparam int CW_CE_N   = 8;
    localparam int CW_LI_N   = 7;
    localparam int CW_EI_N   = 6;
    localparam int CW_LA_N   = 5;
    localparam int CW_EA     = 4;
    localparam int CW_SU     = 3;
    localparam int CW_EU     = 2;
    localparam int CW_LB_N   = 1;
    localparam int CW_LO_N   = 0;

    localparam logic [11:0] CW_INACTIVE  = 12'h3E3;
    localparam logic [11:0] CW_FETCH_T1  = 12'h5E3;
    localparam logic [11:0] CW_FETCH_T2  = 12'hBE3;
    localparam logic [11:0] CW_FETCH_T3  = 12'h263;
    localparam logic [11:0] CW_MEM_ADDR  = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5    = 12'h2C3;
    localparam logic [11:0] CW_LOAD_B    = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6    = 12'h3C7;
    localparam logic [11:0] CW_SUB_T6    = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4    = 12'h3F2;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // True when exactly one ring bit is set.
    function automatic logic is_onehot6(input logic [5:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return (cnt == 3'd1);
    endfunction

    // Control word for a given ring position, opcode and halt state.
    function automatic logic [11:0] decode_cw(input logic [5:0] t,
                                              input logic [3:0] op,
                                              input logic       h);
        logic [11:0] cw;
        cw = CW_INACTIVE;
        if (h) begin
            cw = CW_INACTIVE;
        end else begin
            case (t)
                T1: cw = CW_FETCH_T1;
                T2: cw = CW_FETCH_T2;
                T3: cw = CW_FETCH_T3;
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: cw = CW_MEM_ADDR;
                        OP_OUT:                 cw = CW_OUT_T4;
                        default:                cw = CW_INACTIVE;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA:         cw = CW_LDA_T5;
                        OP_ADD, OP_SUB: cw = CW_LOAD_B;
                        default:        cw = CW_INACTIVE;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD:  cw = CW_ADD_T6;
                        OP_SUB:  cw = CW_SUB_T6;
                        default: cw = CW_INACTIVE;
                    endcase
                end
                default: cw = CW_INACTIVE;
            endcase
        end
        return cw;
    endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter_6.sv
// Six-position one-hot ring (T1..T6), advancing on the falling clock edge,
// with a hold input and recovery to T1 from any non-one-hot state.
module ring_counter_6
    import controller_sequencer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hold,
    output logic [5:0] o_ring
);

    logic [5:0] r_ring;

    // Ring register: rotate, hold, or resynchronise to T1 if corrupted.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ring <= T1;
        end else if (!is_onehot6(r_ring)) begin
            r_ring <= T1;
        end else if (i_hold) begin
            r_ring <= r_ring;
        end else begin
            r_ring <= {r_ring[4:0], r_ring[5]};
        end
    end

    assign o_ring = r_ring;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring-counter timing, halt flag and
// combinational decode of the 12-bit control word.
module controller_sequencer
    import controller_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        low_async_reset,
    input  logic [3:0]  opcode,
    output logic [11:0] control_word,
    output logic [5:0]  t_state,
    output logic        halted
);

    logic [5:0]  w_ring;
    logic        r_halted;
    logic        w_halt_set;
    logic        w_hold;
    logic [11:0] w_cw;

    // The edge that leaves T4 on HLT must already freeze the ring.
    assign w_halt_set = (w_ring == T4) && (opcode == OP_HLT);
    assign w_hold     = r_halted | w_halt_set;

    ring_counter_6 u_ring (
        .i_clk   (clk),
        .i_rst_n (low_async_reset),
        .i_hold  (w_hold),
        .o_ring  (w_ring)
    );

    // Halt flag: set when HLT leaves T4, cleared only by reset.
    always_ff @(negedge clk or negedge low_async_reset) begin
        if (!low_async_reset) begin
            r_halted <= 1'b0;
        end else if (w_halt_set) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end

    // Decode depends only on registered ring/halt state plus opcode.
    always_comb begin
        w_cw = CW_INACTIVE;
        w_cw = decode_cw(w_ring, opcode, r_halted);
    end

    assign control_word = w_cw;
    assign t_state      = w_ring;
    assign halted       = r_halted;

endmodule
